decode_stage: RTL and testbench

Registered, handshaked instruction-decode pipeline stage for the rysyCore family, parametrised in data width (RV32/RV64) and register-file size (I/E). It accepts a fetched instruction plus PC, performs field extraction, format classification, immediate selection with sign extension to XLEN, and legality checking. It presents one decoded bundle per cycle to execute. A two-entry skid buffer keeps `in_ready` registered.

---
 rtl/decode_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, handshaked instruction-decode stage: field extraction, format
// classification, immediate sign extension and legality check, behind a 2-entry skid buffer.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_E = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_func3,
   output logic [6:0]      out_func7,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } bundle_t;

   state_t         state, next_state;
   logic           in_ready_q;
   bundle_t        dec, out_q, skid_q;
   logic           in_xfer, out_xfer;
   logic           load_out_in, load_out_skid, load_skid;

   logic [2:0]        fmt_raw;
   logic              bad;
   logic              uses_rd, uses_rs1, uses_rs2;
   logic [5:0]        shamt_hi6;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   imm_ext;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = (state != EMPTY) & out_ready;

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.opcode  = in_inst[6:0];
      dec.func3   = in_inst[14:12];
      dec.func7   = in_inst[31:25];
      dec.rd      = in_inst[11:7];
      dec.rs1     = in_inst[19:15];
      dec.rs2     = in_inst[24:20];
      fmt_raw     = FMT_ILL;
      bad         = 1'b0;
      uses_rd     = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      shamt_hi6   = in_inst[31:26];
      imm32       = '0;

      case (dec.opcode)
         OP_LUI, OP_AUIPC: fmt_raw = FMT_U;
         OP_JAL:           fmt_raw = FMT_J;
         OP_JALR, OP_LOAD, OP_OPIMM, OP_MISC, OP_SYSTEM: fmt_raw = FMT_I;
         OP_STORE:         fmt_raw = FMT_S;
         OP_BRANCH:        fmt_raw = FMT_B;
         OP_OP:            fmt_raw = FMT_R;
         OP_IMM32:         if (XLEN == 64) fmt_raw = FMT_I;
         OP_OP32:          if (XLEN == 64) fmt_raw = FMT_R;
         default:          fmt_raw = FMT_ILL;
      endcase

      if (in_inst[1:0] != 2'b11 || fmt_raw == FMT_ILL) bad = 1'b1;

      if (fmt_raw == FMT_R) begin
         if (dec.func7 != 7'h00 && dec.func7 != 7'h20) bad = 1'b1;
         if (dec.func7 == 7'h20 && dec.func3 != 3'b000 && dec.func3 != 3'b101) bad = 1'b1;
      end

      // RV64 shifts use a 6-bit shamt, so only inst[31:26] carries the func bits
      if (dec.opcode == OP_OPIMM && (dec.func3 == 3'b001 || dec.func3 == 3'b101)) begin
         if (XLEN == 64) begin
            if (!(shamt_hi6 == 6'h00 || (shamt_hi6 == 6'h10 && dec.func3 == 3'b101))) bad = 1'b1;
         end else begin
            if (!(dec.func7 == 7'h00 || (dec.func7 == 7'h20 && dec.func3 == 3'b101))) bad = 1'b1;
         end
      end

      case (fmt_raw)
         FMT_R:        begin uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         FMT_I:        begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
         FMT_S, FMT_B: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         FMT_U, FMT_J: uses_rd = 1'b1;
         default:      ;
      endcase
      if (ENABLE_E && ((uses_rd && dec.rd[4]) || (uses_rs1 && dec.rs1[4]) || (uses_rs2 && dec.rs2[4])))
         bad = 1'b1;

      case (fmt_raw)
         FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         FMT_U:   imm32 = {in_inst[31:12], 12'b0};
         FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm_ext = XLEN'(imm32);

      if (bad) begin
         dec.fmt     = FMT_ILL;
         dec.imm     = '0;
         dec.illegal = 1'b1;
      end else begin
         dec.fmt     = fmt_raw;
         dec.imm     = imm_ext;
         dec.illegal = 1'b0;
      end
   end

   // in_ready is a pure register so downstream backpressure never reaches upstream combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= next_state;
         in_ready_q <= (next_state != TWO);
      end
   end

   always_comb begin
      next_state    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         next_state = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_xfer) begin
               next_state  = ONE;
               load_out_in = 1'b1;
            end
            ONE: begin
               if (in_xfer && !out_xfer) begin
                  next_state = TWO;
                  load_skid  = 1'b1;
               end else if (!in_xfer && out_xfer) begin
                  next_state = EMPTY;
               end else if (in_xfer && out_xfer) begin
                  load_out_in = 1'b1;
               end
            end
            TWO: if (out_xfer) begin
               next_state    = ONE;
               load_out_skid = 1'b1;
            end
            default: next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in)        out_q <= dec;
         else if (load_out_skid) out_q <= skid_q;
         if (load_skid)          skid_q <= dec;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state != EMPTY);
   assign out_pc      = out_q.pc;
   assign out_opcode  = out_q.opcode;
   assign out_func3   = out_q.func3;
   assign out_func7   = out_q.func7;
   assign out_rd      = out_q.rd;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: three configurations (RV32I, RV32E, RV64I) share one
// stimulus stream; each has its own expected-bundle queue drained by an independent monitor.
module tb_decode_stage;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [2:0]  fmt;
      logic [63:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b0;

   logic        rdy_a, vld_a, ill_a;
   logic [31:0] pc_a, imm_a;
   logic [6:0]  opc_a, f7_a;
   logic [2:0]  f3_a, fmt_a;
   logic [4:0]  rd_a, rs1_a, rs2_a;

   logic        rdy_e, vld_e, ill_e;
   logic [31:0] pc_e, imm_e;
   logic [6:0]  opc_e, f7_e;
   logic [2:0]  f3_e, fmt_e;
   logic [4:0]  rd_e, rs1_e, rs2_e;

   logic        rdy_w, vld_w, ill_w;
   logic [63:0] pc_w, imm_w;
   logic [6:0]  opc_w, f7_w;
   logic [2:0]  f3_w, fmt_w;
   logic [4:0]  rd_w, rs1_w, rs2_w;

   exp_t q_a[$];
   exp_t q_e[$];
   exp_t q_w[$];
   exp_t ea, ee, ew;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ENABLE_E(1'b0)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld_a), .out_ready(out_ready),
      .out_pc(pc_a), .out_opcode(opc_a), .out_func3(f3_a), .out_func7(f7_a),
      .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_imm(imm_a),
      .out_fmt(fmt_a), .out_illegal(ill_a));

   decode_stage #(.XLEN(32), .ENABLE_E(1'b1)) dut_e (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_e),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld_e), .out_ready(out_ready),
      .out_pc(pc_e), .out_opcode(opc_e), .out_func3(f3_e), .out_func7(f7_e),
      .out_rd(rd_e), .out_rs1(rs1_e), .out_rs2(rs2_e), .out_imm(imm_e),
      .out_fmt(fmt_e), .out_illegal(ill_e));

   decode_stage #(.XLEN(64), .ENABLE_E(1'b0)) dut_w (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w),
      .in_inst(in_inst), .in_pc(64'(in_pc)), .out_valid(vld_w), .out_ready(out_ready),
      .out_pc(pc_w), .out_opcode(opc_w), .out_func3(f3_w), .out_func7(f7_w),
      .out_rd(rd_w), .out_rs1(rs1_w), .out_rs2(rs2_w), .out_imm(imm_w),
      .out_fmt(fmt_w), .out_illegal(ill_w));

   // Single comparison point: every check in the bench funnels through here
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic compareBundle(input string tag, input exp_t e, input logic [63:0] pc,
                                input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                                input logic [31:0] fields);
      checkOutput({tag, ".pc"}, pc, e.pc);
      checkOutput({tag, ".fmt"}, 64'(fmt), 64'(e.fmt));
      checkOutput({tag, ".imm"}, imm, e.imm);
      checkOutput({tag, ".illegal"}, 64'(ill), 64'(e.fmt == 3'd7));
      checkOutput({tag, ".fields"}, 64'(fields),
                  64'({e.inst[6:0], e.inst[14:12], e.inst[31:25], e.inst[11:7], e.inst[19:15], e.inst[24:20]}));
   endtask

   // Monitors: pop an expectation whenever an output transfer is about to happen
   always @(negedge clk) begin
      if (!rst && vld_a === 1'b1 && out_ready) begin
         checkOutput("rv32.expected_pending", 64'(q_a.size() != 0), 64'd1);
         if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            compareBundle("rv32", ea, 64'(pc_a), 64'(imm_a), fmt_a, ill_a,
                          {opc_a, f3_a, f7_a, rd_a, rs1_a, rs2_a});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && vld_e === 1'b1 && out_ready) begin
         checkOutput("rv32e.expected_pending", 64'(q_e.size() != 0), 64'd1);
         if (q_e.size() != 0) begin
            ee = q_e.pop_front();
            compareBundle("rv32e", ee, 64'(pc_e), 64'(imm_e), fmt_e, ill_e,
                          {opc_e, f3_e, f7_e, rd_e, rs1_e, rs2_e});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && vld_w === 1'b1 && out_ready) begin
         checkOutput("rv64.expected_pending", 64'(q_w.size() != 0), 64'd1);
         if (q_w.size() != 0) begin
            ew = q_w.pop_front();
            compareBundle("rv64", ew, pc_w, imm_w, fmt_w, ill_w,
                          {opc_w, f3_w, f7_w, rd_w, rs1_w, rs2_w});
         end
      end
   end

   // Drive one instruction until accepted and queue the hand-computed result for each config
   task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [2:0] fmt32, input logic [31:0] imm32,
                                input logic [2:0] fmt32e, input logic [2:0] fmt64,
                                input logic [63:0] imm64);
      bit   took = 1'b0;
      exp_t e;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rdy_a && rdy_e && rdy_w) begin
            took = 1'b1;
            break;
         end
      end
      checkOutput("input_accepted", 64'(took), 64'd1);
      if (took) begin
         e.pc = 64'(pc); e.inst = inst;
         e.fmt = fmt32;  e.imm = 64'(imm32);
         q_a.push_back(e);
         e.fmt = fmt32e; e.imm = (fmt32e == 3'd7) ? 64'd0 : 64'(imm32);
         q_e.push_back(e);
         e.fmt = fmt64;  e.imm = imm64;
         q_w.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q_a.size() == 0 && q_e.size() == 0 && q_w.size() == 0) break;
      end
      checkOutput("drain.rv32", 64'(q_a.size()), 64'd0);
      checkOutput("drain.rv32e", 64'(q_e.size()), 64'd0);
      checkOutput("drain.rv64", 64'(q_w.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset.in_ready", 64'({rdy_a, rdy_e, rdy_w}), 64'b111);
      checkOutput("reset.out_valid", 64'({vld_a, vld_e, vld_w}), 64'b000);
      checkOutput("reset.out_pc", pc_w, 64'd0);
      checkOutput("reset.out_imm", imm_w | 64'(imm_a), 64'd0);
      checkOutput("reset.fields", 64'({opc_a, f3_a, f7_a, rd_a, rs1_a, rs2_a, fmt_a, ill_a}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // inst, pc, fmt32, imm32, fmt32e, fmt64, imm64
      applyStimulus(32'hFFF10093, 32'h100, 3'd1, 32'hFFFFFFFF, 3'd1, 3'd1, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("latency.out_valid", 64'(vld_a), 64'd1);
      checkOutput("latency.out_pc", 64'(pc_a), 64'h100);
      applyStimulus(32'hFE000EE3, 32'h104, 3'd3, 32'hFFFFFFFC, 3'd3, 3'd3, 64'hFFFFFFFFFFFFFFFC);
      applyStimulus(32'h001000EF, 32'h108, 3'd5, 32'h00000800, 3'd5, 3'd5, 64'h800);
      applyStimulus(32'h00000000, 32'h10C, 3'd7, 32'h0,        3'd7, 3'd7, 64'h0);
      applyStimulus(32'h802081B3, 32'h110, 3'd7, 32'h0,        3'd7, 3'd7, 64'h0);
      applyStimulus(32'h00208833, 32'h114, 3'd0, 32'h0,        3'd7, 3'd0, 64'h0);
      applyStimulus(32'h800000B7, 32'h118, 3'd4, 32'h80000000, 3'd4, 3'd4, 64'hFFFFFFFF80000000);
      applyStimulus(32'h0010809B, 32'h11C, 3'd7, 32'h0,        3'd7, 3'd1, 64'h1);
      applyStimulus(32'h03F09093, 32'h120, 3'd7, 32'h0,        3'd7, 3'd1, 64'h3F);
      applyStimulus(32'h402081B3, 32'h124, 3'd0, 32'h0,        3'd0, 3'd0, 64'h0);
      applyStimulus(32'h0020A423, 32'h128, 3'd2, 32'h8,        3'd2, 3'd2, 64'h8);
      applyStimulus(32'h4030D093, 32'h12C, 3'd1, 32'h403,      3'd1, 3'd1, 64'h403);
      applyStimulus(32'h402091B3, 32'h130, 3'd7, 32'h0,        3'd7, 3'd7, 64'h0);
      waitDrain();

      // Backpressure: A and B fill the buffer, C must wait until the output drains
      out_ready = 1'b0;
      applyStimulus(32'h00100093, 32'h200, 3'd1, 32'h1, 3'd1, 3'd1, 64'h1);
      applyStimulus(32'h00200113, 32'h204, 3'd1, 32'h2, 3'd1, 3'd1, 64'h2);
      @(negedge clk);
      checkOutput("two.in_ready_low", 64'({rdy_a, rdy_e, rdy_w}), 64'b000);
      fork
         applyStimulus(32'h00300193, 32'h208, 3'd1, 32'h3, 3'd1, 3'd1, 64'h3);
         begin
            repeat (3) @(posedge clk);
            #1;
            checkOutput("hold.in_ready", 64'(rdy_a), 64'd0);
            checkOutput("hold.out_valid", 64'(vld_a), 64'd1);
            checkOutput("hold.out_pc_stable", 64'(pc_a), 64'h200);
            out_ready = 1'b1;
         end
      join
      waitDrain();

      // Flush while both entries are full, with a competing input offered
      out_ready = 1'b0;
      applyStimulus(32'h00400213, 32'h300, 3'd1, 32'h4, 3'd1, 3'd1, 64'h4);
      applyStimulus(32'h00500293, 32'h304, 3'd1, 32'h5, 3'd1, 3'd1, 64'h5);
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00600313; in_pc = 32'h308;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      q_a.delete(); q_e.delete(); q_w.delete();
      @(negedge clk);
      checkOutput("flush.out_valid", 64'({vld_a, vld_e, vld_w}), 64'b000);
      checkOutput("flush.in_ready", 64'({rdy_a, rdy_e, rdy_w}), 64'b111);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      // Flush in EMPTY with an input transfer in the same cycle: that input is dropped
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h30C;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("flush.no_output", 64'({vld_a, vld_e, vld_w}), 64'b000);
      @(posedge clk);
      #1;
      applyStimulus(32'h00800413, 32'h310, 3'd1, 32'h8, 3'd1, 3'd1, 64'h8);
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
